// File: rtl/interp_output_serializer_if.sv
// Handshake bundle between the interpolation filter, the output serializer
// and the downstream consumer. The slave modport is the serializer's view.
interface interp_output_serializer_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int NPHASE = 15
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NPHASE-1:0][IN_W-1:0]    y;
  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_W-1:0]               out_data;
  logic [3:0]                     out_phase;
  logic                           out_last;

  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, out_data, out_phase, out_last
  );

  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, out_data, out_phase, out_last
  );
endinterface

// File: rtl/interp_output_serializer.sv
// Captures one set of 15 interpolated phases from the filter and emits them
// one phase per accepted beat, rounded by 2^SHIFT and saturated to OUT_W.
//
// state  | meaning
// S_IDLE | no set held, ready to capture
// S_EMIT | set captured, out_valid high, walking phases 0..NPHASE-1
module interp_output_serializer #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6,
  parameter int NPHASE = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  interp_output_serializer_if.slave    bus
);

  localparam logic [3:0]             LAST_PH = 4'(NPHASE - 1);
  localparam logic signed [IN_W:0]   RND     = (IN_W+1)'(1 << (SHIFT - 1));
  localparam logic signed [IN_W:0]   SAT_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0]   SAT_MIN = ~SAT_MAX;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NPHASE-1:0][IN_W-1:0]  r_cap;
  logic [3:0]                   r_phase;
  logic [OUT_W-1:0]             r_data;
  logic [3:0]                   w_phase_inc;
  logic                         w_last;
  logic                         w_capture;
  logic                         w_advance;
  logic                         w_drain;

  // Round half toward +inf, then clamp; the extra headroom bit keeps +32767 from wrapping.
  function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] y);
    logic signed [IN_W:0] v_ext;
    logic signed [IN_W:0] v_sum;
    logic signed [IN_W:0] v_shr;
    v_ext = $signed({y[IN_W-1], y});
    v_sum = v_ext + RND;
    v_shr = v_sum >>> SHIFT;
    if (v_shr > SAT_MAX)
      conv = SAT_MAX[OUT_W-1:0];
    else if (v_shr < SAT_MIN)
      conv = SAT_MIN[OUT_W-1:0];
    else
      conv = v_shr[OUT_W-1:0];
  endfunction

  assign w_last      = (r_state == S_EMIT) && (r_phase == LAST_PH);
  assign w_phase_inc = r_phase + 4'd1;

  // A new set is taken when idle, or in the same cycle the last beat of the
  // current set is accepted so back-to-back sets have no bubble.
  assign bus.in_ready  = (r_state == S_IDLE) || (w_last && bus.out_ready);
  assign bus.out_valid = (r_state == S_EMIT);
  assign bus.out_last  = w_last;
  assign bus.out_phase = r_phase;
  assign bus.out_data  = r_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (w_last) begin
            if (bus.in_valid) begin
              w_capture = 1'b1;
            end else begin
              w_drain     = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
      end
    endcase
  end

  // Capture registers and the registered output sample; held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap   <= '0;
      r_phase <= 4'd0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_cap   <= bus.y;
      r_phase <= 4'd0;
      r_data  <= conv(bus.y[0]);
    end else if (w_advance) begin
      r_phase <= w_phase_inc;
      r_data  <= conv(r_cap[w_phase_inc]);
    end else if (w_drain) begin
      r_phase <= 4'd0;
      r_data  <= '0;
    end
  end

endmodule

// File: tb/tb_interp_output_serializer.sv
// Bench for interp_output_serializer: directed table sets, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_interp_output_serializer;

  logic clk;
  logic rst;

  interp_output_serializer_if #(.IN_W(16), .OUT_W(8), .NPHASE(15)) bus ();

  interp_output_serializer #(.IN_W(16), .OUT_W(8), .SHIFT(6), .NPHASE(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    int y   [15];
    int exp [15];
  } vec_t;

  typedef struct {
    int data;
    int phase;
  } beat_t;

  vec_t  tbl [4];
  beat_t sb [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion: floor((y + 32) / 64), clamped to signed 8 bits.
  function automatic int ref_conv(input int y);
    int v;
    int q;
    v = y + 32;
    q = (v >= 0) ? (v / 64) : -((-v + 63) / 64);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_y(input int y [15]);
    for (int i = 0; i < 15; i++) bus.y[i] = 16'(y[i]);
  endtask

  function automatic int out_d();
    return int'($signed(bus.out_data));
  endfunction

  // Presents a set for one cycle; afterwards phase 0 should be on the output.
  task automatic send_set(input int y [15]);
    drive_y(y);
    bus.in_valid = 1'b1;
    #1;
    check("send_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int ph, input int exp_d);
    #1;
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_phase"}, int'(bus.out_phase), ph);
    check({tag, "_data"},  out_d(), exp_d);
    check({tag, "_last"},  int'(bus.out_last), (ph == 14) ? 1 : 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    for (int i = 0; i < 15; i++) begin
      tbl[0].y[i] = 64 * i;   tbl[0].exp[i] = i;
      tbl[1].y[i] = 0;        tbl[1].exp[i] = 0;
      tbl[2].y[i] = 0;        tbl[2].exp[i] = 0;
      tbl[3].y[i] = -64;      tbl[3].exp[i] = -1;
    end
    tbl[1].y[0] = 32;     tbl[1].exp[0] = 1;
    tbl[1].y[1] = -32;    tbl[1].exp[1] = 0;
    tbl[1].y[2] = -33;    tbl[1].exp[2] = -1;
    tbl[1].y[3] = 95;     tbl[1].exp[3] = 1;
    tbl[1].y[4] = 96;     tbl[1].exp[4] = 2;
    tbl[2].y[0] = 8191;   tbl[2].exp[0] = 127;
    tbl[2].y[1] = 32767;  tbl[2].exp[1] = 127;
    tbl[2].y[2] = -8256;  tbl[2].exp[2] = -128;
    tbl[2].y[3] = -32768; tbl[2].exp[3] = -128;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.y         = '0;
    tick();
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data",  out_d(), 0);
    check("rst_out_phase", int'(bus.out_phase), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    tick();

    // Table sets, out_ready held high: 15 back-to-back beats then idle.
    for (int t = 0; t < 4; t++) begin
      send_set(tbl[t].y);
      for (int p = 0; p < 15; p++) begin
        check_beat($sformatf("tbl%0d_p%0d", t, p), p, tbl[t].exp[p]);
        check($sformatf("tbl%0d_p%0d_in_ready", t, p), int'(bus.in_ready), (p == 14) ? 1 : 0);
        tick();
      end
      #1;
      check($sformatf("tbl%0d_idle", t), int'(bus.out_valid), 0);
      tick();
    end

    // Backpressure at phase 3; a competing set during the stall must be ignored.
    send_set(tbl[0].y);
    for (int p = 0; p < 3; p++) tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      drive_y(tbl[3].y);
      check_beat($sformatf("bp_hold%0d", c), 3, 3);
      check("bp_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    for (int p = 4; p < 15; p++) begin
      check_beat($sformatf("bp_p%0d", p), p, p);
      tick();
    end
    #1;
    check("bp_idle", int'(bus.out_valid), 0);
    tick();

    // Back-to-back: next set offered during the accepted last beat.
    send_set(tbl[0].y);
    for (int p = 0; p < 14; p++) tick();
    check_beat("b2b_last", 14, 14);
    drive_y(tbl[3].y);
    bus.in_valid = 1'b1;
    #1;
    check("b2b_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    for (int p = 0; p < 15; p++) begin
      check_beat($sformatf("b2b_p%0d", p), p, -1);
      tick();
    end
    #1;
    check("b2b_idle", int'(bus.out_valid), 0);
    tick();

    // Asynchronous reset in the middle of a set.
    send_set(tbl[0].y);
    for (int p = 0; p < 7; p++) tick();
    check_beat("rstmid_p7", 7, 7);
    rst = 1'b1;
    #1;
    check("rstmid_valid", int'(bus.out_valid), 0);
    check("rstmid_data",  out_d(), 0);
    check("rstmid_phase", int'(bus.out_phase), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_in_ready", int'(bus.in_ready), 1);
    send_set(tbl[1].y);
    check_beat("rstmid_new_p0", 0, 1);
    for (int p = 0; p < 15; p++) tick();
    #1;
    check("rstmid_idle", int'(bus.out_valid), 0);
    tick();

    // Randomized traffic against the scoreboard.
    begin
      int    ry [15];
      int    n_sets;
      bit    exp_ir;
      bit    exp_ov;
      beat_t b;
      n_sets = 0;
      sb.delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!bus.in_valid && ($urandom_range(0, 2) == 0)) begin
          for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 3))
              0: ry[i] = int'($signed(16'($urandom)));
              1: ry[i] = $urandom_range(0, 400) - 200;
              2: ry[i] = $urandom_range(0, 200) + 8100 - ((($urandom & 1) != 0) ? 16400 : 0);
              default: ry[i] = (($urandom & 1) != 0) ? 32767 : -32768;
            endcase
          end
          drive_y(ry);
          bus.in_valid = 1'b1;
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_ov = (sb.size() != 0);
        exp_ir = (sb.size() == 0) || (sb.size() == 1 && bus.out_ready);
        check("rnd_in_ready",  int'(bus.in_ready),  int'(exp_ir));
        check("rnd_out_valid", int'(bus.out_valid), int'(exp_ov));
        if (exp_ov) begin
          check("rnd_data",  out_d(), sb[0].data);
          check("rnd_phase", int'(bus.out_phase), sb[0].phase);
          check("rnd_last",  int'(bus.out_last), (sb[0].phase == 14) ? 1 : 0);
          if (bus.out_ready) void'(sb.pop_front());
        end
        if (bus.in_valid && exp_ir) begin
          for (int i = 0; i < 15; i++) begin
            b.data  = ref_conv(ry[i]);
            b.phase = i;
            sb.push_back(b);
          end
          n_sets++;
        end
        @(posedge clk);
        #1;
        if (bus.in_valid && exp_ir) bus.in_valid = 1'b0;
      end
      check("rnd_sets_seen", int'(n_sets > 10), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
